// File: rtl/kasumi_pkg.sv
// Shared types and constants for the kasumi program loader.
package kasumi_pkg;

  typedef enum logic [2:0] {
    HUNT,
    HDR_BASE,
    HDR_LEN,
    PAYLOAD,
    WRITE,
    CSUM,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  localparam logic [31:0] DEFAULT_MAGIC = 32'h494D_534B;

endpackage

// File: rtl/kasumi_byte_packer.sv
// Assembles four strobed bytes into a little-endian word; the completed word
// is presented combinationally on the cycle its fourth byte is strobed.
module kasumi_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        clear,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  count;
  logic [23:0] partial;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count   <= 2'd0;
      partial <= 24'd0;
    end else if (strobe) begin
      count   <= count + 2'd1;
      partial <= {data, partial[23:8]};
    end
  end

  assign word       = {data, partial};
  assign word_valid = strobe && (count == 2'd3);

endmodule

// File: rtl/kasumi_prog_loader.sv
// Framed byte-stream loader: hunts for MAGIC, writes COUNT words from BASE
// upward and releases the core only after the payload checksum verifies.
import kasumi_pkg::*;

module kasumi_prog_loader #(
  parameter logic [31:0] MAGIC         = DEFAULT_MAGIC,
  parameter int unsigned MAX_WORDS     = 65536,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        load,
  output logic [31:0] load_addr,
  output logic [31:0] load_data,
  output logic        reset_sys,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  state_t      state, next_state;
  logic [31:0] hunt_sr, hunt_next;
  logic [31:0] base_r, count_r, idx, sum;
  logic [31:0] word;
  logic        word_valid, accept, pack_strobe;
  logic        magic_hit, csum_ok;
  logic [1:0]  fault;

  assign rx_ready    = (state != WRITE) && (state != ERROR);
  assign load        = (state == WRITE);
  assign accept      = rx_valid && rx_ready;
  assign hunt_next   = {rx_data, hunt_sr[31:8]};
  assign pack_strobe = accept && (state inside {HDR_BASE, HDR_LEN, PAYLOAD, CSUM});

  kasumi_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .strobe     (pack_strobe),
    .clear      (magic_hit),
    .data       (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    magic_hit  = 1'b0;
    csum_ok    = 1'b0;
    fault      = ERR_NONE;
    case (state)
      HUNT:
        if (accept && hunt_next == MAGIC) begin
          next_state = HDR_BASE;
          magic_hit  = 1'b1;
        end
      HDR_BASE:
        if (word_valid) begin
          if (word[1:0] != 2'b00) begin
            next_state = ERROR;
            fault      = ERR_ALIGN;
          end else begin
            next_state = HDR_LEN;
          end
        end
      HDR_LEN:
        if (word_valid) begin
          if (word > 32'(MAX_WORDS)) begin
            next_state = ERROR;
            fault      = ERR_LEN;
          end else if (word == 32'd0) begin
            next_state = CSUM;
          end else begin
            next_state = PAYLOAD;
          end
        end
      PAYLOAD:
        if (word_valid) next_state = WRITE;
      WRITE:
        next_state = (idx + 32'd1 == count_r) ? CSUM : PAYLOAD;
      CSUM:
        if (word_valid) begin
          if (word == sum) begin
            next_state = HUNT;
            csum_ok    = 1'b1;
          end else begin
            next_state = ERROR;
            fault      = ERR_CSUM;
          end
        end
      ERROR:
        next_state = HUNT;
      default:
        next_state = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hunt_sr   <= 32'd0;
      base_r    <= 32'd0;
      count_r   <= 32'd0;
      idx       <= 32'd0;
      sum       <= 32'd0;
      load_addr <= 32'd0;
      load_data <= 32'd0;
      reset_sys <= HOLD_ON_RESET;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      case (state)
        HUNT: begin
          if (accept) hunt_sr <= magic_hit ? 32'd0 : hunt_next;
          if (magic_hit) begin
            busy      <= 1'b1;
            reset_sys <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            sum       <= 32'd0;
            idx       <= 32'd0;
          end
        end
        HDR_BASE: if (word_valid) base_r <= word;
        HDR_LEN: if (word_valid) begin
          count_r <= word;
          idx     <= 32'd0;
        end
        PAYLOAD: if (word_valid) begin
          load_data <= word;
          load_addr <= base_r + {idx[29:0], 2'b00};
        end
        WRITE: begin
          sum <= sum + load_data;
          idx <= idx + 32'd1;
        end
        CSUM: if (csum_ok) begin
          done      <= 1'b1;
          busy      <= 1'b0;
          reset_sys <= 1'b0;
        end
        ERROR: begin
          error     <= 1'b1;
          busy      <= 1'b0;
          reset_sys <= 1'b1;
        end
        default: ;
      endcase
      if (fault != ERR_NONE) err_code <= fault;
      // Payload bytes must never combine with later bytes into a false magic.
      if (state != HUNT && next_state == HUNT) hunt_sr <= 32'd0;
    end
  end

endmodule
